// File: rtl/wta_pkg.sv
// Shared types and helpers for the winner-take-all LIF scheduler.
package wta_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_UPDATE  = 2'd1,
    ST_RESOLVE = 2'd2
  } wta_state_t;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_THRESHOLD     = 127;
  localparam int DEF_INHIBIT_SHIFT = 2;

  // Unsigned add that clamps at max_val instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) begin
      return max_val;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational single-neuron leaky integrate-and-fire step:
// nxt = sat(cur + st/2), hit when nxt reaches THRESHOLD.
module lif_update
  import wta_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int THRESHOLD = DEF_THRESHOLD
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] st,
  output logic [WIDTH-1:0] nxt,
  output logic             hit
);

  localparam logic [31:0] MAX_VAL = (32'd1 << WIDTH) - 32'd1;

  assign nxt = WIDTH'(sat_add(32'(cur), 32'(st >> 1), MAX_VAL));
  assign hit = (32'(nxt) >= 32'(THRESHOLD));

endmodule

// File: rtl/wta_scheduler.sv
// Time-multiplexed LIF scheduler: one neuron update per clock, then a
// one-cycle winner-take-all resolve with lateral inhibition.
module wta_scheduler
  import wta_pkg::*;
#(
  parameter int N_NEURONS     = 4,
  parameter int WIDTH         = DEF_WIDTH,
  parameter int THRESHOLD     = DEF_THRESHOLD,
  parameter int INHIBIT_SHIFT = DEF_INHIBIT_SHIFT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_NEURONS*WIDTH-1:0]     current,
  input  logic                           step,
  output logic                           busy,
  output logic                           done,
  output logic [N_NEURONS-1:0]           spike_vec,
  output logic                           winner_valid,
  output logic [$clog2(N_NEURONS)-1:0]   winner_idx,
  output logic [N_NEURONS*WIDTH-1:0]     state_flat
);

  localparam int IDX_W = $clog2(N_NEURONS);

  wta_state_t               fsm_reg;
  logic [IDX_W-1:0]         idx_reg;
  logic [N_NEURONS-1:0]     hit_reg;
  logic                     any_hit_reg;
  logic [IDX_W-1:0]         best_idx_reg;
  logic [WIDTH-1:0]         best_val_reg;
  logic                     busy_reg;
  logic                     done_reg;
  logic [N_NEURONS-1:0]     spike_vec_reg;
  logic                     winner_valid_reg;
  logic [IDX_W-1:0]         winner_idx_reg;

  logic [N_NEURONS*WIDTH-1:0] cur_snap_flat;
  logic [WIDTH-1:0]           cur_sel;
  logic [WIDTH-1:0]           st_sel;
  logic [WIDTH-1:0]           upd_nxt;
  logic                       upd_hit;
  logic                       take_best;
  logic                       is_last;
  logic                       accept;

  assign accept  = (fsm_reg == ST_IDLE) && step;
  assign is_last = (idx_reg == IDX_W'(N_NEURONS - 1));

  assign cur_sel = cur_snap_flat[idx_reg*WIDTH +: WIDTH];
  assign st_sel  = state_flat[idx_reg*WIDTH +: WIDTH];

  lif_update #(
    .WIDTH     (WIDTH),
    .THRESHOLD (THRESHOLD)
  ) u_lif (
    .cur (cur_sel),
    .st  (st_sel),
    .nxt (upd_nxt),
    .hit (upd_hit)
  );

  // Strict '>' in ascending index order makes the lowest index win ties.
  assign take_best = upd_hit && (!any_hit_reg || (upd_nxt > best_val_reg));

  // Per-neuron storage: input snapshot plus membrane state.
  for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
    logic [WIDTH-1:0] cur_reg;
    logic [WIDTH-1:0] st_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cur_reg <= '0;
        st_reg  <= '0;
      end else begin
        if (accept) begin
          cur_reg <= current[gi*WIDTH +: WIDTH];
        end
        if ((fsm_reg == ST_UPDATE) && (idx_reg == IDX_W'(gi))) begin
          st_reg <= upd_nxt;
        end else if ((fsm_reg == ST_RESOLVE) && any_hit_reg) begin
          st_reg <= (best_idx_reg == IDX_W'(gi)) ? '0 : (st_reg >> INHIBIT_SHIFT);
        end
      end
    end

    assign cur_snap_flat[gi*WIDTH +: WIDTH] = cur_reg;
    assign state_flat[gi*WIDTH +: WIDTH]    = st_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_reg          <= ST_IDLE;
      idx_reg          <= '0;
      hit_reg          <= '0;
      any_hit_reg      <= 1'b0;
      best_idx_reg     <= '0;
      best_val_reg     <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      spike_vec_reg    <= '0;
      winner_valid_reg <= 1'b0;
      winner_idx_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (fsm_reg)
        ST_IDLE: begin
          if (step) begin
            fsm_reg      <= ST_UPDATE;
            idx_reg      <= '0;
            hit_reg      <= '0;
            any_hit_reg  <= 1'b0;
            best_idx_reg <= '0;
            best_val_reg <= '0;
            busy_reg     <= 1'b1;
          end
        end
        ST_UPDATE: begin
          hit_reg[idx_reg] <= upd_hit;
          if (take_best) begin
            any_hit_reg  <= 1'b1;
            best_idx_reg <= idx_reg;
            best_val_reg <= upd_nxt;
          end
          if (is_last) begin
            fsm_reg <= ST_RESOLVE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        ST_RESOLVE: begin
          spike_vec_reg    <= hit_reg;
          winner_valid_reg <= any_hit_reg;
          winner_idx_reg   <= any_hit_reg ? best_idx_reg : '0;
          busy_reg         <= 1'b0;
          done_reg         <= 1'b1;
          fsm_reg          <= ST_IDLE;
        end
        default: begin
          fsm_reg  <= ST_IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign spike_vec    = spike_vec_reg;
  assign winner_valid = winner_valid_reg;
  assign winner_idx   = winner_idx_reg;

endmodule
